x_demux_align_alct: RTL and testbench



---
 rtl/alct_demux_pkg.sv | 20 ++
 rtl/x_delay_tap.sv | 34 +++
 rtl/x_demux_align_alct.sv | 158 +++++++++++++++
 tb/tb_x_demux_align_alct.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alct_demux_pkg.sv
// Shared FSM encoding and counter sizing for the ALCT demux aligner.
package alct_demux_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHunt,
        StSettle,
        StLock,
        StFail
    } state_t;

    localparam int unsigned ErrW = 16;
    localparam logic [ErrW-1:0] ErrMax = '1;

    // Bits needed to hold the values 0..n.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/x_delay_tap.sv
// Whole-cycle delay line with a selectable tap; sel=0 passes din straight through.
module x_delay_tap #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned SELW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic [SELW-1:0]  sel,
    output logic [WIDTH-1:0] dout
);

    // line[i] holds din delayed by i+1 clocks
    logic [WIDTH-1:0] line [DEPTH-1];
    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH - 1; i++) line[i] <= '0;
        end else begin
            line[0] <= din;
            for (int i = 1; i < DEPTH - 1; i++) line[i] <= line[i-1];
        end
    end

    always_comb begin
        taps[0] = din;
        for (int i = 1; i < DEPTH; i++) taps[i] = line[i-1];
    end

    assign dout = taps[sel];

endmodule

// File: rtl/x_demux_align_alct.sv
// Half-cycle swap, selectable delay and training-pattern alignment FSM for ALCT demux data.
module x_demux_align_alct
    import alct_demux_pkg::*;
#(
    parameter int unsigned      WIDTH    = 16,
    parameter int unsigned      MXDLY    = 4,
    parameter logic [WIDTH-1:0] PAT1ST   = 16'hA5A5,
    parameter logic [WIDTH-1:0] PAT2ND   = 16'h5A5A,
    parameter int unsigned      LOCK_CNT = 8,
    parameter int unsigned      MAX_TRY  = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] din1st,
    input  logic [WIDTH-1:0] din2nd,
    input  logic             posneg,
    input  logic [MXDLY-1:0] delay,
    input  logic             train_en,
    output logic [WIDTH-1:0] dout1st,
    output logic [WIDTH-1:0] dout2nd,
    output logic             swap,
    output logic             locked,
    output logic             align_fail,
    output logic [ErrW-1:0]  err_cnt
);

    localparam int unsigned MW = cnt_width(LOCK_CNT);
    localparam int unsigned TW = cnt_width(MAX_TRY);

    logic [WIDTH-1:0] din2nd_prev, a1, a2, d1, d2;
    logic             match;
    state_t           state;
    logic [MW-1:0]    match_cnt;
    logic [TW-1:0]    try_cnt;
    logic             settle_cnt;
    logic             train_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            din2nd_prev <= '0;
            a1          <= '0;
            a2          <= '0;
        end else begin
            din2nd_prev <= din2nd;
            if (swap) begin
                a1 <= din2nd_prev;
                a2 <= din1st;
            end else begin
                a1 <= din1st;
                a2 <= din2nd;
            end
        end
    end

    x_delay_tap #(.WIDTH(WIDTH), .DEPTH(2**MXDLY)) u_dly1 (
        .clock (clock),
        .reset (reset),
        .din   (a1),
        .sel   (delay),
        .dout  (d1)
    );

    x_delay_tap #(.WIDTH(WIDTH), .DEPTH(2**MXDLY)) u_dly2 (
        .clock (clock),
        .reset (reset),
        .din   (a2),
        .sel   (delay),
        .dout  (d2)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dout1st <= '0;
            dout2nd <= '0;
        end else if (clr) begin
            dout1st <= '0;
            dout2nd <= '0;
        end else begin
            dout1st <= d1;
            dout2nd <= d2;
        end
    end

    assign match = (a1 == PAT1ST) && (a2 == PAT2ND);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= StIdle;
            swap       <= 1'b0;
            locked     <= 1'b0;
            align_fail <= 1'b0;
            err_cnt    <= '0;
            match_cnt  <= '0;
            try_cnt    <= '0;
            settle_cnt <= 1'b0;
            // Treat train_en as already high so a level held through reset is not a rising edge
            train_prev <= 1'b1;
        end else begin
            train_prev <= train_en;
            if (train_en && !train_prev) begin
                state      <= StHunt;
                locked     <= 1'b0;
                align_fail <= 1'b0;
                err_cnt    <= '0;
                match_cnt  <= '0;
                try_cnt    <= '0;
            end else begin
                case (state)
                    StIdle: begin
                        swap   <= posneg;
                        locked <= 1'b0;
                    end
                    StHunt: begin
                        if (!train_en) begin
                            state <= StIdle;
                        end else if (match) begin
                            if (match_cnt == MW'(LOCK_CNT - 1)) begin
                                state  <= StLock;
                                locked <= 1'b1;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            match_cnt  <= '0;
                            swap       <= ~swap;
                            try_cnt    <= try_cnt + 1'b1;
                            settle_cnt <= 1'b0;
                            if (try_cnt == TW'(MAX_TRY - 1)) begin
                                state      <= StFail;
                                align_fail <= 1'b1;
                            end else begin
                                state <= StSettle;
                            end
                        end
                    end
                    StSettle: begin
                        // Two idle clocks let the swapped data reach a1/a2 before comparing
                        if (!train_en) state <= StIdle;
                        else if (settle_cnt) state <= StHunt;
                        else settle_cnt <= 1'b1;
                    end
                    StLock: begin
                        locked <= 1'b1;
                        if (train_en && !match && (err_cnt != ErrMax)) err_cnt <= err_cnt + 1'b1;
                    end
                    StFail: begin
                        locked     <= 1'b0;
                        align_fail <= 1'b1;
                        if (!train_en) state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_x_demux_align_alct.sv
// Scoreboard bench for x_demux_align_alct: timed expectations queued by stimulus, checked by a monitor.
module tb_x_demux_align_alct;

    localparam int KD = 0, KS = 1, KL = 2, KF = 3, KE = 4;

    logic        clock = 1'b0, reset = 1'b1, clr = 1'b0, posneg = 1'b0, train_en = 1'b0;
    logic [15:0] din1st = '0, din2nd = '0;
    logic [3:0]  delay = '0;
    logic [15:0] dout1st, dout2nd, err_cnt;
    logic        swap, locked, align_fail;

    x_demux_align_alct dut (
        .clock      (clock),
        .reset      (reset),
        .clr        (clr),
        .din1st     (din1st),
        .din2nd     (din2nd),
        .posneg     (posneg),
        .delay      (delay),
        .train_en   (train_en),
        .dout1st    (dout1st),
        .dout2nd    (dout2nd),
        .swap       (swap),
        .locked     (locked),
        .align_fail (align_fail),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    typedef struct {
        int          due;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    task automatic expect_at(input int dly, input int kind, input logic [31:0] v, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            KD:      return {dout1st, dout2nd};
            KS:      return {31'd0, swap};
            KL:      return {31'd0, locked};
            KF:      return {31'd0, align_fail};
            default: return {16'd0, err_cnt};
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Monitor: compares every expectation that falls due at this negedge
    initial begin
        forever begin
            @(negedge clock);
            for (int i = sbq.size() - 1; i >= 0; i--) begin
                if (sbq[i].due <= cyc) begin
                    logic [31:0] act;
                    act = observe(sbq[i].kind);
                    tests++;
                    if (sbq[i].due < cyc || act !== sbq[i].exp) begin
                        fails++;
                        $display("FAIL %s: cycle %0d got %h expected %h", sbq[i].name, cyc, act,
                                 sbq[i].exp);
                    end
                    sbq.delete(i);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        reset = 1'b0;
        expect_at(1, KD, 32'd0, "rst_dout");
        expect_at(1, KS, 32'd0, "rst_swap");
        expect_at(1, KL, 32'd0, "rst_locked");
        expect_at(1, KF, 32'd0, "rst_fail");
        expect_at(1, KE, 32'd0, "rst_err");
        tick(3);

        // Latency with delay=0
        din1st = 16'h1234; din2nd = 16'h5678;
        expect_at(1, KD, 32'd0, "lat0_early");
        expect_at(2, KD, 32'h12345678, "lat0");
        tick(1);
        din1st = '0; din2nd = '0;
        expect_at(2, KD, 32'd0, "lat0_after");
        tick(6);

        // Latency with delay=5
        delay = 4'd5;
        tick(3);
        din1st = 16'h1234; din2nd = 16'h5678;
        expect_at(6, KD, 32'd0, "lat5_early");
        expect_at(7, KD, 32'h12345678, "lat5");
        tick(1);
        din1st = '0; din2nd = '0;
        expect_at(7, KD, 32'd0, "lat5_after");
        tick(10);
        delay = 4'd0;
        tick(8);

        // Manual swap in IDLE
        posneg = 1'b1;
        expect_at(1, KS, 32'd1, "posneg_swap");
        tick(1);
        posneg = 1'b0;
        expect_at(1, KS, 32'd0, "posneg_unswap");
        tick(3);

        // Half-cycle offset stream: one toggle, settle, lock after 8 matches
        din1st = 16'h5A5A; din2nd = 16'hA5A5;
        tick(3);
        train_en = 1'b1;
        expect_at(1, KS, 32'd0, "train_swap_pre");
        expect_at(1, KE, 32'd0, "train_err_clr");
        expect_at(2, KS, 32'd1, "train_swap_toggle");
        expect_at(11, KL, 32'd0, "train_locked_early");
        expect_at(12, KL, 32'd1, "train_locked");
        tick(14);
        expect_at(1, KD, 32'hA5A55A5A, "aligned_data");
        tick(2);

        // Three corrupt words while locked
        din1st = 16'h0000;
        expect_at(1, KE, 32'd0, "err_before");
        tick(3);
        din1st = 16'h5A5A;
        expect_at(2, KE, 32'd3, "err_three");
        expect_at(2, KL, 32'd1, "err_still_locked");
        tick(4);

        // Saturation of err_cnt
        din1st = 16'h0000;
        tick(65540);
        din1st = 16'h5A5A;
        expect_at(2, KE, 32'h0000FFFF, "err_saturate");
        expect_at(2, KL, 32'd1, "err_sat_locked");
        tick(4);

        // clr in LOCK
        clr = 1'b1;
        expect_at(1, KD, 32'd0, "clr_dout");
        expect_at(1, KL, 32'd1, "clr_locked");
        expect_at(1, KS, 32'd1, "clr_swap");
        tick(1);
        clr = 1'b0;
        expect_at(1, KD, 32'hA5A55A5A, "after_clr");
        tick(2);
        tests++;
        if ({dout1st, dout2nd} !== 32'hA5A55A5A) begin
            fails++;
            $display("FAIL after_clr_direct: got %h expected %h", {dout1st, dout2nd},
                     32'hA5A55A5A);
        end

        // train_en low in LOCK: data mode, no error counting
        train_en = 1'b0;
        din1st = 16'h0000;
        tick(5);
        expect_at(1, KL, 32'd1, "data_mode_locked");
        expect_at(1, KE, 32'h0000FFFF, "data_mode_err");
        tick(2);

        // Never-matching pattern -> failure after 16 toggles
        din2nd = 16'h0000;
        train_en = 1'b1;
        expect_at(1, KE, 32'd0, "fail_err_clr");
        expect_at(1, KL, 32'd0, "fail_unlock");
        expect_at(46, KF, 32'd0, "fail_early");
        expect_at(47, KF, 32'd1, "fail_set");
        expect_at(47, KL, 32'd0, "fail_locked");
        expect_at(47, KS, 32'd1, "fail_swap");
        tick(50);
        expect_at(1, KF, 32'd1, "fail_hold");
        tick(2);
        tests++;
        if (align_fail !== 1'b1) begin
            fails++;
            $display("FAIL fail_hold_direct: got %b expected %b", align_fail, 1'b1);
        end

        // Back to IDLE, then a new rising edge clears align_fail
        train_en = 1'b0;
        tick(3);
        train_en = 1'b1;
        expect_at(1, KF, 32'd0, "fail_cleared");
        expect_at(1, KS, 32'd0, "idle_swap_posneg");
        tick(3);

        // Reset pulse during HUNT, no clock edge while asserted
        din1st = 16'h1111; din2nd = 16'h2222;
        tick(6);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        expect_at(1, KD, 32'd0, "hunt_rst_dout");
        expect_at(1, KS, 32'd0, "hunt_rst_swap");
        expect_at(1, KL, 32'd0, "hunt_rst_locked");
        expect_at(1, KF, 32'd0, "hunt_rst_fail");
        expect_at(1, KE, 32'd0, "hunt_rst_err");
        tick(1);

        // train_en held across reset is not a rising edge: stay in IDLE
        din1st = 16'hA5A5; din2nd = 16'h5A5A;
        tick(15);
        expect_at(1, KL, 32'd0, "no_rise_after_rst");
        tick(2);
        train_en = 1'b0;
        tick(2);
        train_en = 1'b1;
        expect_at(8, KL, 32'd0, "direct_lock_early");
        expect_at(9, KL, 32'd1, "direct_lock");
        expect_at(9, KS, 32'd0, "direct_lock_swap");
        tick(12);
        tests++;
        if (locked !== 1'b1 || swap !== 1'b0) begin
            fails++;
            $display("FAIL direct_lock_hold: got %b%b expected %b%b", locked, swap, 1'b1, 1'b0);
        end

        for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clock);
        foreach (sbq[i]) begin
            tests++;
            fails++;
            $display("FAIL %s: never checked, got pending expected %h", sbq[i].name, sbq[i].exp);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
